// File: rtl/tl45_pkg.sv
// rtl/tl45_pkg.sv - shared tl45 fetch-path types and constants
//
// Purpose: definitions shared by prefetch, the instruction queue and decode.
//   TL45_BUBBLE_INST : instruction word prefetch emits when it has nothing valid
//   TL45_BUBBLE_PC   : PC shown alongside a bubble
//   tl45_fetch_t     : one fetch packet {pc, inst}
package tl45_pkg;

    localparam logic [31:0] TL45_BUBBLE_INST = 32'hFFFF_FFFF;
    localparam logic [31:0] TL45_BUBBLE_PC   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } tl45_fetch_t;

    function automatic logic is_bubble(input logic [31:0] inst);
        return inst == TL45_BUBBLE_INST;
    endfunction

endpackage

// File: rtl/tl45_inst_queue.sv
// rtl/tl45_inst_queue.sv - instruction queue between prefetch and decode
//
// Purpose: buffers fetch packets from the prefetch stage, drops bubbles and
// presents a first-word-fall-through head to decode. Prefetch is throttled
// through its pipe-stall input so decode back-pressure never loses or
// duplicates an instruction. A flush empties the queue in one cycle.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_flush                 pipeline flush / new PC (same cycle as prefetch)
//   i_buf_pc, i_buf_inst    prefetch registered output (inst all-ones = bubble)
//   o_pfetch_stall          to prefetch pipe-stall input
//   o_dec_valid/pc/inst     head entry presented to decode
//   i_dec_stall             decode cannot take the head this cycle
//   o_count                 occupancy
module tl45_inst_queue
    import tl45_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_flush,
    input  logic [31:0]                i_buf_pc,
    input  logic [31:0]                i_buf_inst,
    output logic                       o_pfetch_stall,
    output logic                       o_dec_valid,
    output logic [31:0]                o_dec_pc,
    output logic [31:0]                o_dec_inst,
    input  logic                       i_dec_stall,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

    tl45_fetch_t     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            r_fresh;

    logic            enq;
    logic            deq;
    logic            empty;
    tl45_fetch_t     head;

    // Prefetch holds its output while stalled, so a word is new only if the
    // stall was low at the previous edge.
    assign enq   = r_fresh && !is_bubble(i_buf_inst) && !i_flush;
    assign empty = (count == '0);
    assign deq   = !empty && !i_dec_stall && !i_flush;

    // Raising the stall one entry early leaves room for the single word
    // already in flight when prefetch first sees it.
    assign o_pfetch_stall = (count >= STALL_LVL);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            r_fresh <= 1'b1;
        end else begin
            r_fresh <= !o_pfetch_stall;
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset; entries are only read once count covers them.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{pc: i_buf_pc, inst: i_buf_inst};
        end
    end

    assign head        = mem[rd_ptr];
    assign o_dec_valid = !empty;
    assign o_dec_pc    = empty ? TL45_BUBBLE_PC   : head.pc;
    assign o_dec_inst  = empty ? TL45_BUBBLE_INST : head.inst;
    assign o_count     = count;

    // Overflow is unreachable given the early stall.
    always @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(enq && count == FULL_LVL));
        end
    end

`ifdef FORMAL
    logic f_past_valid;
    logic f_past_stall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            f_past_valid <= 1'b0;
            f_past_stall <= 1'b0;
        end else begin
            f_past_valid <= 1'b1;
            f_past_stall <= o_pfetch_stall;
        end
    end

    always_comb begin
        if (!i_reset) begin
            assert (count <= FULL_LVL);
            assert (!(enq && count == FULL_LVL));
            assert (PW'(wr_ptr - rd_ptr) == count[PW-1:0]);
            if (f_past_valid && f_past_stall) begin
                assert (!enq);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tl45_inst_queue.sv
// tb/tb_tl45_inst_queue.sv - self-checking bench for tl45_inst_queue
module tb_tl45_inst_queue;

    logic        i_clk;
    logic        i_reset;
    logic        i_flush;
    logic [31:0] i_buf_pc;
    logic [31:0] i_buf_inst;
    logic        o_pfetch_stall;
    logic        o_dec_valid;
    logic [31:0] o_dec_pc;
    logic [31:0] o_dec_inst;
    logic        i_dec_stall;
    logic [2:0]  o_count;

    tl45_inst_queue #(.DEPTH(4)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_flush        (i_flush),
        .i_buf_pc       (i_buf_pc),
        .i_buf_inst     (i_buf_inst),
        .o_pfetch_stall (o_pfetch_stall),
        .o_dec_valid    (o_dec_valid),
        .o_dec_pc       (o_dec_pc),
        .o_dec_inst     (o_dec_inst),
        .i_dec_stall    (i_dec_stall),
        .o_count        (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          pend = 0;
    int          delivered = 0;
    int          max_count = 0;
    int          src_left = 0;
    logic [31:0] next_pc = 32'h0;
    logic        bub_mode = 1'b0;
    logic        bub_tog = 1'b0;
    logic        stall_pre;

    // Prefetch model: produce the next word (or a bubble) once per advance.
    task automatic present();
        if (src_left == 0 || (bub_mode && bub_tog)) begin
            i_buf_pc   = $urandom;
            i_buf_inst = 32'hFFFF_FFFF;
            pend       = 0;
        end else begin
            i_buf_pc   = next_pc;
            i_buf_inst = {16'hC0DE, next_pc[15:0]};
            exp_q.push_back({i_buf_pc, i_buf_inst});
            next_pc    = next_pc + 1;
            src_left   = src_left - 1;
            pend       = 1;
        end
        bub_tog = !bub_tog;
    endtask

    // Called at a negedge: check outputs against the scoreboard, then run one edge.
    task automatic step(input logic dstall);
        i_dec_stall = dstall;
        #0;
        checks++;
        if (int'(o_count) !== exp_q.size() - pend) begin
            errors++;
            $display("FAIL count: got %0d expected %0d", o_count, exp_q.size() - pend);
        end
        checks++;
        if (o_pfetch_stall !== (o_count >= 3'd3)) begin
            errors++;
            $display("FAIL pfetch_stall: got %b with count %0d", o_pfetch_stall, o_count);
        end
        if (int'(o_count) > max_count) max_count = int'(o_count);
        checks++;
        if (o_dec_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL head_unexpected: got %h_%h expected nothing", o_dec_pc, o_dec_inst);
            end else if ({o_dec_pc, o_dec_inst} !== exp_q[0]) begin
                errors++;
                $display("FAIL head: got %h_%h expected %h", o_dec_pc, o_dec_inst, exp_q[0]);
            end
            if (!dstall && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                delivered++;
            end
        end else if ({o_dec_pc, o_dec_inst} !== {32'h0, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL empty_head: got %h_%h expected 00000000_ffffffff", o_dec_pc, o_dec_inst);
        end
        stall_pre = o_pfetch_stall;
        @(posedge i_clk);
        #1;
        pend = 0;
        if (!stall_pre) present();
        @(negedge i_clk);
    endtask

    task automatic run_until(input int n, input int bound, input int rnd, input string name);
        int guard = 0;
        while (delivered < n && guard < bound) begin
            step(rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b0);
            guard++;
        end
        checks++;
        if (delivered != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: delivered %0d expected %0d, left %0d", name, delivered, n, exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({o_dec_valid, o_dec_pc, o_dec_inst, o_pfetch_stall, o_count} !==
            {1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL %s: got v=%b pc=%h inst=%h st=%b cnt=%0d expected v=0 pc=0 inst=ffffffff st=0 cnt=0",
                     name, o_dec_valid, o_dec_pc, o_dec_inst, o_pfetch_stall, o_count);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_flush = 1'b0; i_dec_stall = 1'b0;
        i_buf_pc = 32'h0; i_buf_inst = 32'hFFFF_FFFF;
        #2;
        check_reset_outputs("reset");
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic test_stream();
        int cnt_bad = 0;
        int guard = 0;
        next_pc = 32'h100; src_left = 16; delivered = 0;
        while (delivered < 16 && guard < 40) begin
            if (o_count > 3'd1) cnt_bad++;
            step(1'b0);
            guard++;
        end
        checks++;
        if (cnt_bad != 0 || guard != 18) begin
            errors++;
            $display("FAIL stream_rate: count>1 %0d times, %0d steps expected 18", cnt_bad, guard);
        end
        checks++;
        if (delivered != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drain: delivered %0d expected 16", delivered);
        end
    endtask

    task automatic test_back_pressure();
        next_pc = 32'h200; src_left = 8; delivered = 0; max_count = 0;
        for (int i = 0; i < 8; i++) step(1'b1);
        checks++;
        if (max_count != 4 || o_pfetch_stall !== 1'b1) begin
            errors++;
            $display("FAIL bp_fill: max count %0d stall %b expected 4 and 1", max_count, o_pfetch_stall);
        end
        run_until(8, 60, 0, "bp");
    endtask

    task automatic test_bubbles();
        next_pc = 32'h300; src_left = 6; delivered = 0; bub_mode = 1'b1; bub_tog = 1'b0;
        run_until(6, 60, 0, "bubble");
        bub_mode = 1'b0;
    endtask

    task automatic test_flush();
        next_pc = 32'h400; src_left = 4; delivered = 0;
        for (int i = 0; i < 4; i++) step(1'b1);
        checks++;
        if (o_count !== 3'd3 || pend != 1) begin
            errors++;
            $display("FAIL flush_setup: count %0d pend %0d expected 3 and 1", o_count, pend);
        end
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        exp_q.delete();
        pend = 0;
        i_buf_pc = 32'h0; i_buf_inst = 32'hFFFF_FFFF;
        @(negedge i_clk);
        check_reset_outputs("flush");
        next_pc = 32'h480; src_left = 4;
        run_until(4, 40, 0, "flush");
    endtask

    task automatic test_wrap();
        next_pc = 32'h500; src_left = 20; delivered = 0;
        run_until(20, 300, 1, "wrap");
    endtask

    task automatic test_async_reset();
        next_pc = 32'h600; src_left = 3; delivered = 0;
        for (int i = 0; i < 3; i++) step(1'b1);
        checks++;
        if (o_count === 3'd0) begin
            errors++;
            $display("FAIL areset_setup: count %0d expected nonzero", o_count);
        end
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        pend = 0; src_left = 0;
        i_buf_pc = 32'h0; i_buf_inst = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_reset = 1'b0;
        next_pc = 32'h700; src_left = 2; delivered = 0;
        run_until(2, 20, 0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_bubbles();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
